// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers.
package pipe_pkg;

  localparam int unsigned OCC_W      = 2;
  localparam int unsigned CTRL_W_DEF = 4;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_TWO   = 2'd2;

  // Bit positions inside the control bundle.
  localparam int unsigned CTRL_MEM_RD  = 0;
  localparam int unsigned CTRL_MEM_WR  = 1;
  localparam int unsigned CTRL_REG_WR  = 2;
  localparam int unsigned CTRL_FLAG_WR = 3;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_TWO   = OCC_TWO
  } occ_state_e;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One storage slot of the stage: valid + control + data, with load and clear.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 26,
  parameter int unsigned CTRL_W     = CTRL_W_DEF,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Control and valid are always reset/cleared so no spurious writes escape.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
    end
  end

  // Data may skip reset/clear to save toggling power.
  if (CLEAR_DATA) begin : g_data_clr
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data <= '0;
      end else if (clear) begin
        data <= '0;
      end else if (load) begin
        data <= ld_data;
      end
    end
  end else begin : g_data_keep
    always_ff @(posedge clk) begin
      if (load) begin
        data <= ld_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic stage register with a 2-entry skid buffer and flush support.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 26,
  parameter int unsigned CTRL_W     = CTRL_W_DEF,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  occ_state_e state_q, state_d;
  logic       in_ready_q;

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;
  logic accept, drain;

  // A beat offered during flush is dropped, never accepted.
  assign accept = in_valid & in_ready_q & ~flush;
  assign drain  = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !drain) begin
            skid_load = 1'b1;
            state_d   = ST_TWO;
          end else if (accept && drain) begin
            main_load = 1'b1;
          end else if (drain) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the skid promotion can happen.
          if (drain) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_entry #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clear   (main_clear),
    .ld_data (main_from_skid ? skid_data : in_data),
    .ld_ctrl (main_from_skid ? skid_ctrl : in_ctrl),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  pipe_entry #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .ld_data (in_data),
    .ld_ctrl (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = OCC_W'(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table plus reset and CLEAR_DATA=0 sequences.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 26;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  logic          nc_flush, nc_in_valid, nc_out_ready;
  logic [DW-1:0] nc_in_data;
  logic [CW-1:0] nc_in_ctrl;
  logic          nc_in_ready, nc_out_valid;
  logic [DW-1:0] nc_out_data;
  logic [CW-1:0] nc_out_ctrl;
  logic [1:0]    nc_occupancy;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .flush(nc_flush),
    .in_valid(nc_in_valid), .in_ready(nc_in_ready), .in_data(nc_in_data), .in_ctrl(nc_in_ctrl),
    .out_valid(nc_out_valid), .out_ready(nc_out_ready), .out_data(nc_out_data),
    .out_ctrl(nc_out_ctrl), .occupancy(nc_occupancy)
  );

  typedef struct {
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          chk_data;
    logic [CW-1:0] e_ctrl;
    logic [1:0]    e_occ;
    logic          e_ready;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void add(input logic f, input logic iv, input logic ordy,
                              input logic [DW-1:0] id, input logic [CW-1:0] ic,
                              input logic ev, input logic [DW-1:0] ed, input logic cd,
                              input logic [CW-1:0] ec, input logic [1:0] eo, input logic er);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.in_data = id; v.in_ctrl = ic;
    v.e_valid = ev; v.e_data = ed; v.chk_data = cd; v.e_ctrl = ec; v.e_occ = eo; v.e_ready = er;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic ordy,
                       input logic [DW-1:0] id, input logic [CW-1:0] ic);
    flush = f; in_valid = iv; out_ready = ordy; in_data = id; in_ctrl = ic;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end within 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    nc_flush = 1'b0; nc_in_valid = 1'b0; nc_out_ready = 1'b0; nc_in_data = '0; nc_in_ctrl = '0;

    // Streaming 0x01..0x10, then drain to empty.
    for (int i = 1; i <= 16; i++)
      add(0, 1, 1, DW'(i), 4'b0100, 1, DW'(i), 1, 4'b0100, 2'd1, 1);
    add(0, 0, 1, '0, '0, 0, '0, 0, '0, 2'd0, 1);
    // Stall: A, B fill the stage, C waits, then A, B, C emerge in order.
    add(0, 1, 0, 26'h0AA, 4'b0001, 1, 26'h0AA, 1, 4'b0001, 2'd1, 1);
    add(0, 1, 0, 26'h0BB, 4'b0010, 1, 26'h0AA, 1, 4'b0001, 2'd2, 0);
    add(0, 1, 0, 26'h0C3, 4'b1000, 1, 26'h0AA, 1, 4'b0001, 2'd2, 0);
    add(0, 1, 0, 26'h0C3, 4'b1000, 1, 26'h0AA, 1, 4'b0001, 2'd2, 0);
    add(0, 1, 1, 26'h0C3, 4'b1000, 1, 26'h0BB, 1, 4'b0010, 2'd1, 1);
    add(0, 1, 1, 26'h0C3, 4'b1000, 1, 26'h0C3, 1, 4'b1000, 2'd1, 1);
    add(0, 0, 1, '0, '0, 0, '0, 0, '0, 2'd0, 1);
    // Flush while TWO with a beat offered: it must never appear.
    add(0, 1, 0, 26'h011, 4'b0100, 1, 26'h011, 1, 4'b0100, 2'd1, 1);
    add(0, 1, 0, 26'h022, 4'b0100, 1, 26'h011, 1, 4'b0100, 2'd2, 0);
    add(1, 1, 0, 26'h0CC, 4'b0100, 0, 26'h000, 1, 4'b0000, 2'd0, 1);
    add(0, 0, 1, '0, '0, 0, '0, 0, '0, 2'd0, 1);
    // Flush and drain together in ONE, with a beat offered and in_ready high.
    add(0, 1, 0, 26'h033, 4'b0100, 1, 26'h033, 1, 4'b0100, 2'd1, 1);
    add(1, 1, 1, 26'h0CC, 4'b0100, 0, 26'h000, 1, 4'b0000, 2'd0, 1);
    add(0, 0, 1, '0, '0, 0, '0, 0, '0, 2'd0, 1);
    // Control gating after final drain.
    add(0, 1, 0, 26'h044, 4'b0011, 1, 26'h044, 1, 4'b0011, 2'd1, 1);
    add(0, 0, 1, '0, '0, 0, '0, 0, '0, 2'd0, 1);

    // Reset held: in_ready low, stage empty.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_nc_out_ctrl", 32'(nc_out_ctrl), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].in_data, vecs[i].in_ctrl);
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].e_ctrl));
      check($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      if (vecs[i].chk_data)
        check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_data));
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    // CLEAR_DATA=0: flush leaves stale data visible but gates valid/ctrl.
    nc_in_valid = 1'b1; nc_in_data = 26'h155; nc_in_ctrl = 4'b0110; nc_out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("nc_load_valid", 32'(nc_out_valid), 32'd1);
    check("nc_load_data", 32'(nc_out_data), 32'h155);
    check("nc_load_ctrl", 32'(nc_out_ctrl), 32'b0110);
    nc_in_valid = 1'b0; nc_flush = 1'b1;
    @(posedge clk);
    #1;
    nc_flush = 1'b0;
    check("nc_flush_valid", 32'(nc_out_valid), 32'd0);
    check("nc_flush_ctrl", 32'(nc_out_ctrl), 32'd0);
    check("nc_flush_occ", 32'(nc_occupancy), 32'd0);
    check("nc_flush_data", 32'(nc_out_data), 32'h155);
    check("nc_flush_in_ready", 32'(nc_in_ready), 32'd1);

    // Reset mid-stream with two beats held and a third offered.
    drive(1'b0, 1'b1, 1'b0, 26'h0D1, 4'b0100);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 26'h0D2, 4'b0100);
    @(posedge clk);
    #1;
    check("mid_occ_before", 32'(occupancy), 32'd2);
    drive(1'b0, 1'b1, 1'b0, 26'h0D3, 4'b0100);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ctrl", 32'(out_ctrl), 32'd0);
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    check("mid_rel_occ", 32'(occupancy), 32'd0);
    check("mid_rel_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed EX/MEM stage register.
- Moves one instruction bundle per cycle between two pipeline stages using a valid/ready handshake.
- Contains a 2-entry skid buffer, so the ready path is fully registered and a downstream stall never loses an instruction.
- Supports flush (NOP injection) with control-field zeroing; instantiated at every stage boundary (ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 26, width of the datapath bundle (e.g. alu_result, rb, addr, rd packed).
- CTRL_W, 4, width of the control bundle (mem_read, mem_write, reg_write, flag_write); zeroed whenever the stage holds no valid instruction.
- CLEAR_DATA, 1, 1 = data entries also cleared to 0 on reset/flush; 0 = data left unchanged (power saving).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  cancel every instruction held in the stage; synchronous.
- in_valid  input  1  upstream presents a valid bundle.
- in_ready  output  1  stage can accept; registered output.
- in_data  input  DATA_W  upstream datapath bundle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- out_valid  output  1  stage presents a valid bundle.
- out_ready  input  1  downstream accepts (0 = stall).
- out_data  output  DATA_W  datapath bundle to next stage.
- out_ctrl  output  CTRL_W  control bundle; forced to 0 when out_valid=0.
- occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Storage:
  - main entry drives out_*.
  - skid entry captures an accepted beat when main is full and not draining.
- States (from occupancy): EMPTY(0), ONE(1), TWO(2).
- Transfer rules:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- Transitions:
  - EMPTY: accept -> ONE (main <= in).
  - ONE: accept & !drain -> TWO (skid <= in). !accept & drain -> EMPTY. accept & drain -> ONE (main <= in). Neither -> hold.
  - TWO: drain -> ONE (main <= skid). in_ready=0, so there is no accept.
- in_ready is registered: in_ready = (next occupancy != 2). It is low exactly while in TWO.
- Latency: 1 cycle in_valid -> out_valid when EMPTY. Throughput is 1 beat/cycle while out_ready=1.
- Ordering: strictly FIFO. Skid contents always precede any new beat.
- Flush:
  - Highest priority after reset.
  - Next cycle: occupancy=0, out_valid=0, out_ctrl=0, in_ready=1.
  - Any beat offered in the flush cycle is dropped, not accepted; upstream sees in_ready, but the flush contract covers it.
  - Data entries are cleared iff CLEAR_DATA=1.
- Stall (out_ready=0 while out_valid=1): out_data and out_ctrl hold stable. One further beat is absorbed into skid, then in_ready drops.
- Reset (rst=0, any time, mid-transfer included):
  - Outputs: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1. in_ready=1 is applied on the first clock after release; it is 0 while rst is asserted.
  - All state is lost.
- out_ctrl gating is combinational: out_ctrl = out_valid ? main_ctrl : 0, so downstream never sees spurious mem/reg writes.
- Simultaneous flush & drain: flush wins. The draining beat is still considered consumed by downstream in that cycle.
- No X propagation: with CLEAR_DATA=0, un-reset data may be X, but out_ctrl is always defined.

Decomposition:
- Shared package pipe_pkg:
  - occupancy encodings OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2.
  - default CTRL_W and the bit indices of the control bundle (CTRL_MEM_RD=0, CTRL_MEM_WR=1, CTRL_REG_WR=2, CTRL_FLAG_WR=3).
- One natural sub-module, pipe_entry: a single DATA_W+CTRL_W+valid register with load, clear and CLEAR_DATA handling. It is instantiated twice (main, skid).

Test Plan:
- Reset mid-stream: 3 beats in flight (occupancy=2), rst pulse -> out_valid=0, out_ctrl=0, occupancy=0; in_ready=1 on the first clock after release.
- Streaming: out_ready=1, beats data=0x01..0x10 with ctrl=4'b0100 each cycle -> identical sequence at out one cycle later, no bubbles, in_ready stays 1.
- Stall/skid:
  - Send A=0x0AA, B=0x0BB; out_ready=0 from cycle 1.
  - Expected: out_data holds 0x0AA, occupancy=2, in_ready=0; C offered is not accepted.
  - Release out_ready: outputs A, B, C in order.
- Flush while TWO: flush=1 with in_valid=1 (data 0x0CC) -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x0CC never appears at out.
- Control gating: load ctrl=4'b0011, then drain with in_valid=0 -> after drain out_ctrl=0 and out_valid=0 in the same cycle.
- CLEAR_DATA=0 variant: flush a held beat 0x155 -> out_valid=0, out_ctrl=0, out_data still 0x155.
